// File: rtl/dmac_copy_ctrl_if.sv
// Host port and RAM port of the copy controller bundled together.
// The slave modport is the controller's view; the master modport belongs to the host/RAM side.
interface dmac_copy_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              h_cen;
  logic              h_wen;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_din;
  logic              h_gnt;
  logic [DATA_W-1:0] h_dout;
  logic              m_cen;
  logic              m_wen;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_din;
  logic [DATA_W-1:0] m_dout;

  modport slave (
    input  h_cen, h_wen, h_addr, h_din, m_dout,
    output h_gnt, h_dout, m_cen, m_wen, m_addr, m_din
  );

  modport master (
    output h_cen, h_wen, h_addr, h_din, m_dout,
    input  h_gnt, h_dout, m_cen, m_wen, m_addr, m_din
  );
endinterface

// File: rtl/dmac_copy_ctrl.sv
// Block-copy DMA controller: copies LEN words SRC->DST (read, wait, write per word)
// and passes the host straight through to the RAM while idle.
module dmac_copy_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  dmac_copy_ctrl_if.slave   bus,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RWAIT, S_WR, S_FIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [LEN_W-1:0]  idx_inc;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  // Address sums wrap naturally at the ADDR_W boundary.
  assign idx_inc = idx_q + LEN_W'(1);
  assign rd_addr = src_q + ADDR_W'(idx_q);
  assign wr_addr = dst_q + ADDR_W'(idx_q);

  assign bus.h_dout = bus.m_dout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    idx_d      = idx_q;
    data_d     = data_q;
    bus.m_cen  = 1'b0;
    bus.m_wen  = 1'b0;
    bus.m_addr = '0;
    bus.m_din  = '0;
    bus.h_gnt  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy       = 1'b0;
        bus.h_gnt  = 1'b1;
        bus.m_cen  = bus.h_cen;
        bus.m_wen  = bus.h_wen;
        bus.m_addr = bus.h_addr;
        bus.m_din  = bus.h_din;
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = length;
          idx_d   = '0;
          state_d = (length == '0) ? S_FIN : S_RD;
        end
      end
      S_RD: begin
        bus.m_cen  = 1'b1;
        bus.m_addr = rd_addr;
        state_d    = S_RWAIT;
      end
      // Address held a second cycle so the registered RAM output is captured here.
      S_RWAIT: begin
        bus.m_cen  = 1'b1;
        bus.m_addr = rd_addr;
        data_d     = bus.m_dout;
        state_d    = S_WR;
      end
      S_WR: begin
        bus.m_cen  = 1'b1;
        bus.m_wen  = 1'b1;
        bus.m_addr = wr_addr;
        bus.m_din  = data_q;
        idx_d      = idx_inc;
        state_d    = (idx_inc == len_q) ? S_FIN : S_RD;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmac_copy_ctrl.sv
// Bench for dmac_copy_ctrl: behavioural RAM plus a shadow memory model of the copy rule.
module tb_dmac_copy_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] src_addr, dst_addr, length;
  logic        busy, done;

  dmac_copy_ctrl_if #(.DATA_W(32), .ADDR_W(16)) bus ();

  dmac_copy_ctrl #(.DATA_W(32), .ADDR_W(16), .LEN_W(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem    [0:65535];
  logic [31:0] shadow [0:65535];
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          rd_addr_q[$];
  int          exp_wa[$];
  logic [31:0] exp_wd[$];
  int          exp_ra[$];
  int          cen_cnt  = 0;
  int          done_cnt = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  // Single-port RAM with registered read data.
  always @(posedge clk) begin
    if (bus.m_cen) begin
      cen_cnt++;
      if (bus.m_wen) begin
        mem[bus.m_addr] <= bus.m_din;
        wr_addr_q.push_back(int'(bus.m_addr));
        wr_data_q.push_back(bus.m_din);
      end else begin
        bus.m_dout <= mem[bus.m_addr];
        rd_addr_q.push_back(int'(bus.m_addr));
      end
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
  endtask

  // Reference: words are moved one at a time in ascending order, addresses mod 2^16.
  function automatic void model_copy(input logic [15:0] s, input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] as_, ad_;
      as_ = s + 16'(i);
      ad_ = d + 16'(i);
      exp_ra.push_back(int'(as_));
      exp_ra.push_back(int'(as_));
      shadow[ad_] = shadow[as_];
      exp_wa.push_back(int'(ad_));
      exp_wd.push_back(shadow[ad_]);
    end
  endfunction

  function automatic int log_errs();
    int e = 0;
    if (wr_addr_q.size() != exp_wa.size() || rd_addr_q.size() != exp_ra.size()) return 1000;
    foreach (exp_wa[i]) if (wr_addr_q[i] != exp_wa[i] || wr_data_q[i] !== exp_wd[i]) e++;
    foreach (exp_ra[i]) if (rd_addr_q[i] != exp_ra[i]) e++;
    return e;
  endfunction

  function automatic int mem_errs();
    int e = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] !== shadow[a]) e++;
    return e;
  endfunction

  task automatic host_write(input logic [15:0] a, input logic [31:0] d);
    bus.h_cen = 1'b1; bus.h_wen = 1'b1; bus.h_addr = a; bus.h_din = d;
    tick();
    bus.h_cen = 1'b0; bus.h_wen = 1'b0;
    shadow[a] = d;
  endtask

  task automatic host_read(input logic [15:0] a, output logic [31:0] d);
    bus.h_cen = 1'b1; bus.h_wen = 1'b0; bus.h_addr = a;
    tick();
    d = bus.h_dout;
    bus.h_cen = 1'b0;
  endtask

  // Returns the cycle (start edge = cycle 1) in which done was seen.
  task automatic do_copy(input logic [15:0] s, input logic [15:0] d, input int n, output int cyc);
    int limit;
    limit = 3 * n + 20;
    src_addr = s; dst_addr = d; length = 16'(n); start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < limit) begin
      tick();
      cyc++;
    end
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.h_gnt !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b h_gnt=%b, want 0 0 1", busy, done, bus.h_gnt);
    end
    bus.h_cen = 1'b1; bus.h_wen = 1'b0; bus.h_addr = 16'h1234;
    #1;
    tests_run++;
    if (bus.m_cen !== 1'b1 || bus.m_addr !== 16'h1234) begin
      tests_failed++;
      $display("FAIL reset_passthrough: m_cen=%b m_addr=%h, want 1 1234", bus.m_cen, bus.m_addr);
    end
    bus.h_cen = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    logic [31:0] d;
    host_write(16'd2, 32'h1111);
    host_read(16'd2, d);
    tests_run++;
    if (d !== 32'h1111) begin
      tests_failed++;
      $display("FAIL host_readback: got %h, want 00001111", d);
    end
    tests_run++;
    if (bus.h_gnt !== 1'b1) begin
      tests_failed++;
      $display("FAIL host_gnt_idle: got %b, want 1", bus.h_gnt);
    end
  endtask

  task automatic test_copy();
    int cyc, dc;
    logic [31:0] d;
    host_write(16'd0, 32'd10000); host_write(16'd1, 32'd20000);
    host_write(16'd2, 32'd30000); host_write(16'd3, 32'd40000);
    clear_logs();
    dc = done_cnt;
    model_copy(16'd0, 16'd8, 4);
    do_copy(16'd0, 16'd8, 4, cyc);
    tests_run++;
    if (cyc != 13) begin
      tests_failed++;
      $display("FAIL copy_done_cycle: got %0d, want 13", cyc);
    end
    tests_run++;
    if (log_errs() != 0 || done_cnt - dc != 1) begin
      tests_failed++;
      $display("FAIL copy_bus_trace: errs=%0d dones=%0d, want 0 1", log_errs(), done_cnt - dc);
    end
    for (int i = 0; i < 4; i++) begin
      host_read(16'(8 + i), d);
      tests_run++;
      if (d !== 32'(10000 * (i + 1))) begin
        tests_failed++;
        $display("FAIL copy_word%0d: got %0d, want %0d", i, d, 10000 * (i + 1));
      end
    end
    tests_run++;
    if (mem_errs() != 0) begin
      tests_failed++;
      $display("FAIL copy_mem: %0d words differ, want 0", mem_errs());
    end
  endtask

  task automatic test_lockout();
    int cyc, dc;
    clear_logs();
    dc = done_cnt;
    model_copy(16'd0, 16'h20, 4);
    src_addr = 16'd0; dst_addr = 16'h20; length = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bus.h_cen = 1'b1; bus.h_wen = 1'b1; bus.h_addr = 16'd8; bus.h_din = 32'hDEAD;
    src_addr = 16'h40; dst_addr = 16'h50; length = 16'd3; start = 1'b1;
    tests_run++;
    if (bus.h_gnt !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL lockout_gnt: h_gnt=%b busy=%b, want 0 1", bus.h_gnt, busy);
    end
    tick();
    start = 1'b0; bus.h_cen = 1'b0; bus.h_wen = 1'b0;
    cyc = 3;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    for (int i = 0; i < 30; i++) tick();
    tests_run++;
    if (cyc != 13 || done_cnt - dc != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL lockout_single_done: cyc=%0d dones=%0d busy=%b, want 13 1 0", cyc, done_cnt - dc, busy);
    end
    tests_run++;
    if (log_errs() != 0 || mem_errs() != 0) begin
      tests_failed++;
      $display("FAIL lockout_no_host_write: trace errs=%0d mem errs=%0d, want 0 0", log_errs(), mem_errs());
    end
  endtask

  task automatic test_len0();
    int cyc, c0;
    clear_logs();
    c0 = cen_cnt;
    do_copy(16'h10, 16'h30, 0, cyc);
    tests_run++;
    if (cyc != 1 || cen_cnt != c0) begin
      tests_failed++;
      $display("FAIL len0: done cycle=%0d ram accesses=%0d, want 1 0", cyc, cen_cnt - c0);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    host_write(16'hFFFF, $urandom);
    host_write(16'h0000, $urandom);
    clear_logs();
    model_copy(16'hFFFF, 16'd4, 2);
    do_copy(16'hFFFF, 16'd4, 2, cyc);
    tests_run++;
    if (log_errs() != 0 || exp_wa[0] != 4 || exp_ra[2] != 0 || cyc != 7) begin
      tests_failed++;
      $display("FAIL wrap_trace: errs=%0d cyc=%0d, want 0 7", log_errs(), cyc);
    end
    tests_run++;
    if (mem_errs() != 0) begin
      tests_failed++;
      $display("FAIL wrap_mem: %0d words differ, want 0", mem_errs());
    end
  endtask

  task automatic test_random();
    int cyc, n;
    logic [15:0] s, d;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(0, 12);
      s = 16'($urandom);
      d = ($urandom_range(0, 1) == 1) ? s + 16'($urandom_range(0, 4)) : 16'($urandom);
      for (int i = 0; i < n; i++) host_write(s + 16'(i), $urandom);
      clear_logs();
      model_copy(s, d, n);
      do_copy(s, d, n, cyc);
      tests_run++;
      if (cyc != ((n == 0) ? 1 : 3 * n + 1) || log_errs() != 0 || mem_errs() != 0) begin
        tests_failed++;
        $display("FAIL random%0d: src=%h dst=%h len=%0d cyc=%0d trace errs=%0d mem errs=%0d, want cyc %0d no errs",
                 it, s, d, n, cyc, log_errs(), mem_errs(), (n == 0) ? 1 : 3 * n + 1);
      end
    end
  endtask

  task automatic test_reset_mid_copy();
    int wr0, dc;
    clear_logs();
    dc = done_cnt;
    src_addr = 16'h100; dst_addr = 16'h200; length = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    tests_run++;
    if (bus.m_wen !== 1'b1 || bus.m_addr !== 16'h200) begin
      tests_failed++;
      $display("FAIL midreset_in_write: m_wen=%b m_addr=%h, want 1 0200", bus.m_wen, bus.m_addr);
    end
    wr0 = wr_addr_q.size();
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.h_gnt !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_state: busy=%b done=%b h_gnt=%b, want 0 0 1", busy, done, bus.h_gnt);
    end
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    tests_run++;
    if (wr_addr_q.size() != wr0 || done_cnt != dc || mem_errs() != 0) begin
      tests_failed++;
      $display("FAIL midreset_aborted: writes=%0d dones=%0d mem errs=%0d, want 0 0 0",
               wr_addr_q.size() - wr0, done_cnt - dc, mem_errs());
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem[a] = $urandom;
      shadow[a] = mem[a];
    end
    start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    bus.h_cen = 1'b0; bus.h_wen = 1'b0; bus.h_addr = '0; bus.h_din = '0;
    bus.m_dout = '0;
    test_reset();
    test_passthrough();
    test_copy();
    test_lockout();
    test_len0();
    test_wrap();
    test_random();
    test_reset_mid_copy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
